// File: rtl/key_pio_pkg.sv
// Shared constants for the debounced key PIO: register addresses,
// edge-mode encodings and the debounce counter sizing helper.
package key_pio_pkg;

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_MODE = 2'd1;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   localparam logic [1:0] MODE_RISE = 2'b00;
   localparam logic [1:0] MODE_FALL = 2'b01;
   localparam logic [1:0] MODE_ANY  = 2'b10;

   function automatic int deb_cnt_width(input int cycles);
      return (cycles > 0) ? $clog2(cycles + 1) : 1;
   endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One input channel: synchroniser chain, stability counter, accepted
// level and single-cycle rise/fall pulses on each accepted change.
module key_debounce_chan
   import key_pio_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CYCLES  = 50000,
   parameter bit IDLE_LEVEL  = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic deb_state,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_out;
   logic                   deb_q;
   logic                   deb_prev;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

   generate
      if (DEB_CYCLES == 0) begin : g_bypass
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               deb_q <= IDLE_LEVEL;
            end else begin
               deb_q <= sync_out;
            end
         end
      end else begin : g_filt
         localparam int CW = deb_cnt_width(DEB_CYCLES);
         localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
         localparam logic [CW-1:0] CNT_MAX  = '1;

         logic [CW-1:0] cnt;

         // Any return to the accepted level restarts the stability window.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt   <= '0;
               deb_q <= IDLE_LEVEL;
            end else if (sync_out == deb_q) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               cnt   <= '0;
               deb_q <= sync_out;
            end else if (cnt != CNT_MAX) begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         deb_prev <= IDLE_LEVEL;
      end else begin
         deb_prev <= deb_q;
      end
   end

   assign deb_state = deb_q;
   assign rise      = deb_q & ~deb_prev;
   assign fall      = ~deb_q & deb_prev;

endmodule

// File: rtl/key_pio_debounced.sv
// Avalon-MM input PIO with per-channel debounce, edge capture and
// masked level interrupt; 2-bit address slave on the data master.
module key_pio_debounced
   import key_pio_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CYCLES  = 50000,
   parameter bit IDLE_LEVEL  = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [WIDTH-1:0] deb;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] edge_q;
   logic [WIDTH-1:0] w1c;
   logic [WIDTH-1:0] edge_capture;
   logic [WIDTH-1:0] irq_mask;
   logic [1:0]       edge_mode;
   logic             wr_en;
   logic [31:0]      rd_mux;
   logic             unused_wdata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      key_debounce_chan #(
         .SYNC_STAGES (SYNC_STAGES),
         .DEB_CYCLES  (DEB_CYCLES),
         .IDLE_LEVEL  (IDLE_LEVEL)
      ) u_chan (
         .clk       (clk),
         .reset_n   (reset_n),
         .din       (in_port[i]),
         .deb_state (deb[i]),
         .rise      (rise[i]),
         .fall      (fall[i])
      );
   end

   assign wr_en        = chipselect & ~write_n;
   assign unused_wdata = ^writedata;

   always_comb begin
      edge_q = rise | fall;
      unique case (edge_mode)
         MODE_RISE: edge_q = rise;
         MODE_FALL: edge_q = fall;
         default:   edge_q = rise | fall;
      endcase
   end

   always_comb begin
      w1c = '0;
      if (wr_en && address == ADDR_EDGE) begin
         w1c = writedata[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edge_mode <= MODE_FALL;
         irq_mask  <= '0;
      end else if (wr_en) begin
         if (address == ADDR_MODE) begin
            edge_mode <= writedata[1:0];
         end
         if (address == ADDR_MASK) begin
            irq_mask <= writedata[WIDTH-1:0];
         end
      end
   end

   // A new edge overrides a same-cycle software clear of that bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edge_capture <= '0;
      end else begin
         edge_capture <= (edge_capture & ~w1c) | edge_q;
      end
   end

   always_comb begin
      rd_mux = '0;
      unique case (address)
         ADDR_DATA: rd_mux[WIDTH-1:0] = deb;
         ADDR_MODE: rd_mux[1:0]       = edge_mode;
         ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
         default:   rd_mux[WIDTH-1:0] = edge_capture;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
      end else begin
         readdata <= rd_mux;
      end
   end

   assign irq = |(edge_capture & irq_mask);

endmodule
